vga_text_writer: RTL
====================

Name: vga_text_writer

Overview:
- Host-side producer for the VGA block-control write port.
- Accepts a byte stream of characters over a valid/ready handshake and keeps a cursor on the 12-row x 32-column cell grid.
- Each character becomes a single-cycle cell write (vga_addr_v, vga_addr_h, vga_ctrl, vga_ctrl_en) into the VGA controller's 384-entry control array.
- Handles the control characters LF, CR, BS and FF, and performs hardware screen clears.

Parameters:
- ROWS, 12, number of cell rows; the cursor row wraps at ROWS-1.
- COLS, 32, number of cell columns; the cursor column wraps at COLS-1.
- FONT_BASE, 8'h20, subtracted from the ASCII code to form font_type.
- BLANK_FONT, 7'd0, font_type written for cleared and backspaced cells.
- RESET_COLOR, 9'h1FF, colour register value after reset.
- CLEAR_ON_RESET, 1, if 1 a full-screen clear runs immediately after reset.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- char_valid  in  1  character byte offered
- char_data  in  8  ASCII byte
- char_ready  out  1  writer accepts char_data this cycle
- color_we  in  1  load the colour register
- color_in  in  9  new colour
- busy  out  1  a clear sequence is in progress
- vga_addr_v  out  4  cell row of the write
- vga_addr_h  out  5  cell column of the write
- vga_ctrl  out  32  cell word: [8:0] colour, [23:9] 0, [31] 0, [30:24] font_type
- vga_ctrl_en  out  1  write strobe, one cycle per cell

Behaviour:
- One clock domain (clk); reset is asynchronous and active-low (rst_n). All outputs are registered.
- Reset values:
  - vga_ctrl_en=0, vga_addr_v=0, vga_addr_h=0, vga_ctrl=0.
  - cursor=(0,0), colour=RESET_COLOR.
  - state=CLR_SCREEN if CLEAR_ON_RESET, else IDLE.
- Reset asserted mid-clear aborts the clear and restarts from the reset state.
- FSM states: IDLE, CLR_SCREEN, CLR_ROW.
- Handshake:
  - char_ready = (state==IDLE).
  - A byte is accepted on a cycle with char_valid && char_ready.
  - The resulting write appears with vga_ctrl_en=1 on the next cycle (latency 1).
  - Back-to-back accepts give one write per cycle.
- Printable bytes 0x20..0x7E:
  - Write the cell at the cursor with font_type=(char_data-FONT_BASE)[6:0] and the current colour.
  - Then col+1. If col was COLS-1: col=0 and row+1; if row was ROWS-1, row wraps to 0.
- LF (0x0A): col=0, row+1 with the same wrap. No write.
- CR (0x0D): col=0. No write.
- BS (0x08):
  - If col>0: col-1 and write BLANK_FONT at the new position.
  - If col==0: no-op, no write, no row change.
- FF (0x0C): enter CLR_SCREEN; cursor=(0,0) when the clear completes.
- All other bytes (<0x20 and not listed, 0x7F, >=0x80): consumed, no effect.
- CLR_SCREEN:
  - Issues ROWS*COLS consecutive writes of BLANK_FONT with the current colour, in row-major order from (0,0).
  - One write per cycle, 384 cycles at the defaults.
  - After the last write, returns to IDLE.
  - busy=1 and char_ready=0 throughout the clear.
- Colour:
  - color_we loads the colour register at the clock edge.
  - A character accepted in the same cycle uses the old colour.
  - color_we is honoured in every state.
- vga_ctrl_en deasserts in every cycle with no write.
- Address counters are 4-bit and 5-bit. The wrap compares against ROWS-1 and COLS-1 explicitly and never relies on natural overflow, because ROWS=12.

Optional Feature:
- Macro: VGA_TEXT_WRITER_LINE_CLEAR_EN.
- Defined:
  - Whenever the cursor enters a new row (LF, or column wrap), the FSM enters CLR_ROW.
  - CLR_ROW writes BLANK_FONT to columns 0..COLS-1 of the new row, 32 cycles, busy=1, char_ready=0.
  - The cursor is left at (new row, 0).
  - When the move happens on a printable character, the character's own write completes first.
- Not defined: the CLR_ROW state is absent and stale row contents persist until overwritten.

Decomposition:
- Shared package vga_pkg:
  - Grid constants VGA_ROWS=12, VGA_COLS=32.
  - vga_ctrl field offsets (COLOR_LSB=0, FONT_LSB=24).
  - ASCII constants for LF, CR, BS, FF.
- One natural sub-module: vga_cursor. It holds the row/col counters with wrap, and advance/newline/cr/back commands.
- The FSM and the output register stay in vga_text_writer.

Test Plan:
- Reset with CLEAR_ON_RESET=1: 384 writes with addresses 0..383 row-major, font 0, ctrl=32'h000001FF; busy then falls; char_ready=1 on the cycle after the last write.
- Send "A" (0x41) at (0,0) with colour 9'h0C0: next cycle addr_v=0, addr_h=0, vga_ctrl=32'h210000C0; cursor moves to (0,1).
- 32 printable chars starting at (11,0): the last write is at (11,31) and the cursor wraps to (0,0); with LINE_CLEAR_EN, 32 blank writes follow to row 0.
- "AB", BS, BS, BS: a blank write at (0,1), then a blank write at (0,0), then no write; cursor ends at (0,0).
- FF issued while at (5,7), with char_valid held: char_ready=0 for 384 cycles, the cursor ends at (0,0), and the held char is accepted immediately afterwards.
- color_we=1 with color_in=9'h007 in the same cycle as accepting "B": "B" is written in the old colour; the next char is written in colour 9'h007.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared grid constants, ASCII control codes, cell-word layout and FSM state type for the VGA text writer.
// The CLR_ROW state exists only when VGA_TEXT_WRITER_LINE_CLEAR_EN is defined.
package vga_pkg;

  localparam int VGA_ROWS  = 12;
  localparam int VGA_COLS  = 32;
  localparam int ROW_W     = 4;
  localparam int COL_W     = 5;

  localparam int COLOR_LSB = 0;
  localparam int FONT_LSB  = 24;

  localparam logic [7:0] ASCII_BS = 8'h08;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_FF = 8'h0C;
  localparam logic [7:0] ASCII_CR = 8'h0D;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    CLR_SCREEN = 2'd1
`ifdef VGA_TEXT_WRITER_LINE_CLEAR_EN
    , CLR_ROW  = 2'd2
`endif
  } wr_state_e;

  function automatic logic [31:0] pack_ctrl(input logic [6:0] font, input logic [8:0] color);
    logic [31:0] w;
    w = '0;
    w[FONT_LSB +: 7]  = font;
    w[COLOR_LSB +: 9] = color;
    return w;
  endfunction

endpackage

// File: rtl/vga_cursor.sv
// Row/column cursor for the text grid. Wraps compare against ROWS-1 / COLS-1 explicitly
// since the 4-bit row counter would otherwise run past row 11.
module vga_cursor
  import vga_pkg::*;
#(
  parameter int ROWS = VGA_ROWS,
  parameter int COLS = VGA_COLS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             home_i,
  input  logic             advance_i,
  input  logic             newline_i,
  input  logic             cr_i,
  input  logic             back_i,
  output logic [ROW_W-1:0] row_o,
  output logic [COL_W-1:0] col_o,
  output logic [ROW_W-1:0] row_next_o,
  output logic             col_last_o
);

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;

  assign row_o      = row_q;
  assign col_o      = col_q;
  assign row_next_o = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
  assign col_last_o = (col_q == COL_LAST);

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (home_i) begin
      row_d = '0;
      col_d = '0;
    end else if (newline_i) begin
      row_d = row_next_o;
      col_d = '0;
    end else if (cr_i) begin
      col_d = '0;
    end else if (back_i) begin
      if (col_q != '0) col_d = col_q - COL_W'(1);
    end else if (advance_i) begin
      if (col_last_o) begin
        col_d = '0;
        row_d = row_next_o;
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

endmodule

// File: rtl/vga_text_writer.sv
// Character-stream producer for the VGA block-control write port, with screen clear on FF/reset.
// Define VGA_TEXT_WRITER_LINE_CLEAR_EN to blank each new row as the cursor enters it.
//
// state      | meaning
// IDLE       | accepting characters, one cell write per printable/BS byte
// CLR_SCREEN | writing BLANK_FONT to every cell in row-major order
// CLR_ROW    | writing BLANK_FONT across the row just entered (line-clear builds only)
module vga_text_writer
  import vga_pkg::*;
#(
  parameter int         ROWS           = VGA_ROWS,
  parameter int         COLS           = VGA_COLS,
  parameter logic [7:0] FONT_BASE      = 8'h20,
  parameter logic [6:0] BLANK_FONT     = 7'd0,
  parameter logic [8:0] RESET_COLOR    = 9'h1FF,
  parameter bit         CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        char_valid,
  input  logic [7:0]  char_data,
  output logic        char_ready,
  input  logic        color_we,
  input  logic [8:0]  color_in,
  output logic        busy,
  output logic [3:0]  vga_addr_v,
  output logic [4:0]  vga_addr_h,
  output logic [31:0] vga_ctrl,
  output logic        vga_ctrl_en
);

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

  wr_state_e        state_q, state_d;
  logic [ROW_W-1:0] clr_v_q, clr_v_d;
  logic [COL_W-1:0] clr_h_q, clr_h_d;
  logic [8:0]       color_q;

  logic             cur_home, cur_adv, cur_nl, cur_cr, cur_back;
  logic [ROW_W-1:0] cur_row, cur_row_next;
  logic [COL_W-1:0] cur_col;
  logic             cur_col_last;

  logic             wr_en;
  logic [ROW_W-1:0] wr_v;
  logic [COL_W-1:0] wr_h;
  logic [6:0]       wr_font;
  logic [6:0]       char_font;
  logic             accept, printable;

  logic             en_q;
  logic [ROW_W-1:0] v_q;
  logic [COL_W-1:0] h_q;
  logic [31:0]      ctrl_q;

  vga_cursor #(.ROWS(ROWS), .COLS(COLS)) u_cursor (
    .clk        (clk),
    .rst_n      (rst_n),
    .home_i     (cur_home),
    .advance_i  (cur_adv),
    .newline_i  (cur_nl),
    .cr_i       (cur_cr),
    .back_i     (cur_back),
    .row_o      (cur_row),
    .col_o      (cur_col),
    .row_next_o (cur_row_next),
    .col_last_o (cur_col_last)
  );

  assign char_ready = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign accept     = char_valid && char_ready;
  assign printable  = (char_data >= 8'h20) && (char_data <= 8'h7E);
  // Bit 7 is always 0 for printable codes, so the 7-bit subtraction matches the 8-bit one.
  assign char_font  = char_data[6:0] - FONT_BASE[6:0];

  always_comb begin
    state_d  = state_q;
    clr_v_d  = clr_v_q;
    clr_h_d  = clr_h_q;
    cur_home = 1'b0;
    cur_adv  = 1'b0;
    cur_nl   = 1'b0;
    cur_cr   = 1'b0;
    cur_back = 1'b0;
    wr_en    = 1'b0;
    wr_v     = cur_row;
    wr_h     = cur_col;
    wr_font  = BLANK_FONT;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (char_data == ASCII_LF) begin
            cur_nl = 1'b1;
`ifdef VGA_TEXT_WRITER_LINE_CLEAR_EN
            state_d = CLR_ROW;
            clr_v_d = cur_row_next;
            clr_h_d = '0;
`endif
          end else if (char_data == ASCII_CR) begin
            cur_cr = 1'b1;
          end else if (char_data == ASCII_BS) begin
            if (cur_col != '0) begin
              cur_back = 1'b1;
              wr_en    = 1'b1;
              wr_h     = cur_col - COL_W'(1);
            end
          end else if (char_data == ASCII_FF) begin
            state_d = CLR_SCREEN;
            clr_v_d = '0;
            clr_h_d = '0;
          end else if (printable) begin
            wr_en   = 1'b1;
            wr_font = char_font;
            cur_adv = 1'b1;
`ifdef VGA_TEXT_WRITER_LINE_CLEAR_EN
            if (cur_col_last) begin
              state_d = CLR_ROW;
              clr_v_d = cur_row_next;
              clr_h_d = '0;
            end
`endif
          end
        end
      end
      CLR_SCREEN: begin
        wr_en = 1'b1;
        wr_v  = clr_v_q;
        wr_h  = clr_h_q;
        if (clr_h_q == COL_LAST) begin
          clr_h_d = '0;
          if (clr_v_q == ROW_LAST) begin
            clr_v_d  = '0;
            state_d  = IDLE;
            cur_home = 1'b1;
          end else begin
            clr_v_d = clr_v_q + ROW_W'(1);
          end
        end else begin
          clr_h_d = clr_h_q + COL_W'(1);
        end
      end
`ifdef VGA_TEXT_WRITER_LINE_CLEAR_EN
      CLR_ROW: begin
        wr_en = 1'b1;
        wr_v  = clr_v_q;
        wr_h  = clr_h_q;
        if (clr_h_q == COL_LAST) begin
          clr_h_d = '0;
          state_d = IDLE;
        end else begin
          clr_h_d = clr_h_q + COL_W'(1);
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if (CLEAR_ON_RESET) state_q <= CLR_SCREEN;
      else                state_q <= IDLE;
      clr_v_q <= '0;
      clr_h_q <= '0;
      color_q <= RESET_COLOR;
    end else begin
      state_q <= state_d;
      clr_v_q <= clr_v_d;
      clr_h_q <= clr_h_d;
      if (color_we) color_q <= color_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q   <= 1'b0;
      v_q    <= '0;
      h_q    <= '0;
      ctrl_q <= '0;
    end else begin
      en_q <= wr_en;
      if (wr_en) begin
        v_q    <= wr_v;
        h_q    <= wr_h;
        ctrl_q <= pack_ctrl(wr_font, color_q);
      end
    end
  end

  assign vga_ctrl_en = en_q;
  assign vga_addr_v  = v_q;
  assign vga_addr_h  = h_q;
  assign vga_ctrl    = ctrl_q;

endmodule
